// File: rtl/pc_gen.sv
// Fetch-stage PC generator: PC register, EX target resolution with mispredict
// redirect, and a direct-mapped BTB with 2-bit saturating counters.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BTB_DEPTH = 16,
  parameter bit              BTB_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [1:0]      ex_npc_op,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_add4,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  output logic            flush
);

  localparam int              IDX    = $clog2(BTB_DEPTH);
  localparam int              TAGW   = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] C_FOUR = XLEN'(4);
  localparam logic [XLEN-1:0] C_LSB  = XLEN'(1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_add4;
  logic            w_btb_taken;
  logic [XLEN-1:0] w_btb_target;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

  logic            w_act_taken;
  logic [XLEN-1:0] w_act_target;
  logic [XLEN-1:0] w_ex_seq;
  logic [XLEN-1:0] w_correct_npc;
  logic            w_mispredict;
  logic            w_flush;
  logic [XLEN-1:0] w_pc_next;

  assign w_pc_add4     = r_pc + C_FOUR;
  assign w_pred_taken  = w_btb_taken;
  assign w_pred_target = w_pred_taken ? w_btb_target : w_pc_add4;

  always_comb begin
    w_act_taken  = 1'b0;
    w_act_target = ex_pc + ex_imm;
    case (ex_npc_op)
      2'b00: w_act_taken = 1'b0;
      2'b01: w_act_taken = ex_taken;
      2'b10: w_act_taken = 1'b1;
      default: begin
        w_act_taken  = 1'b1;
        w_act_target = ex_alu_result & ~C_LSB;
      end
    endcase
  end

  assign w_ex_seq      = ex_pc + C_FOUR;
  assign w_correct_npc = w_act_taken ? w_act_target : w_ex_seq;
  assign w_mispredict  = (w_act_taken != ex_pred_taken) ||
                         (w_act_taken && (w_act_target != ex_pred_target));
  assign w_flush       = ex_valid && w_mispredict && !stall;
  assign w_pc_next     = w_flush ? w_correct_npc : w_pred_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (!stall) begin
      r_pc <= w_pc_next;
    end
  end

  generate
    if (BTB_EN) begin : g_btb
      logic            r_valid [BTB_DEPTH];
      logic [TAGW-1:0] r_tag   [BTB_DEPTH];
      logic [XLEN-1:0] r_tgt   [BTB_DEPTH];
      logic [1:0]      r_ctr   [BTB_DEPTH];

      logic [IDX-1:0]  w_rd_idx;
      logic            w_rd_hit;
      logic [IDX-1:0]  w_wr_idx;
      logic            w_wr_hit;
      logic            w_upd;

      assign w_rd_idx     = r_pc[IDX+1:2];
      assign w_rd_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == r_pc[XLEN-1:IDX+2]);
      assign w_btb_taken  = w_rd_hit && r_ctr[w_rd_idx][1];
      assign w_btb_target = r_tgt[w_rd_idx];

      assign w_wr_idx = ex_pc[IDX+1:2];
      assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == ex_pc[XLEN-1:IDX+2]);
      assign w_upd    = ex_valid && !stall && (ex_npc_op != 2'b00);

      // Lookup reads pre-edge contents, so a same-cycle write is seen next cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < BTB_DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_tag[i]   <= '0;
            r_tgt[i]   <= '0;
            r_ctr[i]   <= 2'b00;
          end
        end else if (w_upd) begin
          if (w_wr_hit) begin
            if (w_act_taken) begin
              if (r_ctr[w_wr_idx] != 2'b11) r_ctr[w_wr_idx] <= r_ctr[w_wr_idx] + 2'd1;
              r_tgt[w_wr_idx] <= w_act_target;
            end else if (r_ctr[w_wr_idx] != 2'b00) begin
              r_ctr[w_wr_idx] <= r_ctr[w_wr_idx] - 2'd1;
            end
          end else if (w_act_taken) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_tag[w_wr_idx]   <= ex_pc[XLEN-1:IDX+2];
            r_tgt[w_wr_idx]   <= w_act_target;
            r_ctr[w_wr_idx]   <= 2'b10;
          end
        end
      end
    end else begin : g_no_btb
      assign w_btb_taken  = 1'b0;
      assign w_btb_target = '0;
    end
  endgenerate

  assign if_pc          = r_pc;
  assign if_pc_add4     = w_pc_add4;
  assign if_pred_taken  = w_pred_taken;
  assign if_pred_target = w_pred_target;
  assign flush          = w_flush;

endmodule
